vc_output_arbiter: RTL
======================

Name: vc_output_arbiter

Overview:
- Per-output-port scheduler for one mesh router. Shares a single outgoing link among NREQ input channels (N, S, E, W, PE).
- Uses the even/odd virtual-channel (VC) scheme. Packet bit 63 selects the VC; `polarity` alternates every cycle.
- Holds one 64-bit buffer per VC. Round-robin arbitration fills the buffer of the current-polarity VC while the link drains the other VC's buffer.
- One instance sits behind each router output port in mesh4x4.

Parameters:
- NREQ, 5, number of requesting input channels (index 0=N, 1=S, 2=E, 3=W, 4=PE).
- DW, 64, packet width; bit DW-1 is the VC bit.
- CW, 16, stall counter width.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  NREQ  per-channel request; held until granted.
- din  input  NREQ*DW  per-channel packet, channel i at bits [i*DW +: DW].
- gnt  output  NREQ  one-hot grant (combinational); packet consumed at the rising edge while gnt[i]=1.
- ro  input  1  downstream ready.
- so  output  1  downstream send strobe (registered).
- dout  output  DW  downstream packet (registered).
- polarity  output  1  current cycle's VC phase.
- stall_cnt  output  CW  saturating count of blocked drain attempts.

Behaviour:
- Reset (reset=0, async):
  - polarity=0, so=0, dout=0, stall_cnt=0, gnt=0.
  - Both full flags cleared, both RR pointers = 0.
  - gnt is forced 0 while reset is low.
- Polarity: toggles on every rising edge after reset releases. Let p = polarity in a given cycle.
- Fill side, VC p only:
  - Eligible(i) = req[i] & din_i[DW-1]==p & !full[p].
  - gnt selects the first eligible i, searching ptr[p], ptr[p]+1, …, wrapping mod NREQ.
  - At the edge: buf[p] <= din_i, full[p] <= 1, ptr[p] <= (i+1) mod NREQ.
  - No eligible requester: gnt=0 and ptr[p] is unchanged.
- Drain side, VC q=~p only:
  - If full[q] & ro, at the edge: so<=1, dout<=buf[q], full[q]<=0.
  - Otherwise so<=0 and dout holds its previous value.
  - If full[q] & !ro: stall_cnt increments, saturating at all-ones (no wrap).
- Because fill and drain never touch the same VC in one cycle, there is no simultaneous read/write hazard on a buffer.
- Latency: grant edge E (polarity p), then drain at edge E+1 (that VC is now "other"). so/dout are visible after E+1, i.e. 2 edges from request to link when ro=1.
- Throughput: at most one packet per VC every 2 cycles, one link transfer per cycle total.
- Backpressure: while full[v] stays set because ro=0, VC v issues no grants. The other VC keeps filling and draining independently whenever its own buffer empties.
- Requests whose VC bit mismatches p are ignored this cycle, not dropped; they are eligible the next cycle.
- Reset mid-operation discards buffered packets; no so pulse is produced for them.
- ptr[0] and ptr[1] are independent.

Test Plan:
- Single packet: after reset release, req[2]=1, din_2=64'h0040_0102_2222_0000 (VC0) while polarity=0 → gnt=5'b00100 in that cycle; next edge so=1, dout=64'h0040_0102_2222_0000; then so=0.
- Round-robin fairness: req=5'b11111, all VC0, ro=1, requests held → grants in order 0,1,2,3,4,0 on successive polarity-0 cycles; so pulses every other cycle with the matching packets.
- VC mismatch: req[4]=1 with bit63=1 presented when polarity=0 → gnt=0 that cycle; gnt[4]=1 the following cycle (polarity=1); so on the cycle after that.
- Backpressure: buf[0] full, ro=0 for 6 cycles → so=0 throughout, no VC0 grant, stall_cnt=3; meanwhile a VC1 packet is still granted and buffered. Raising ro → VC0 packet sent at the next polarity-1 edge.
- Saturation: CW=4, ro=0 held with a full buffer for 40 cycles → stall_cnt=4'hF, no wrap.
- Async reset: assert reset low between edges while both buffers are full → so, dout, gnt, stall_cnt and polarity go 0 immediately. After release, no stale packet is emitted and the first grant starts search at channel 0.

Source files
------------

// File: rtl/vc_output_arbiter.sv
// rtl/vc_output_arbiter.sv - even/odd virtual-channel output-port arbiter with one packet buffer per VC
module vc_output_arbiter #(
  parameter int NREQ = 5,
  parameter int DW   = 64,
  parameter int CW   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] din,
  output logic [NREQ-1:0]    gnt,
  input  logic               ro,
  output logic               so,
  output logic [DW-1:0]      dout,
  output logic               polarity,
  output logic [CW-1:0]      stall_cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // One buffer per VC; the VC matching polarity fills, the other one drains.
  logic [1:0]        full;
  logic [DW-1:0]     vc_buf [2];
  logic [PW-1:0]     ptr    [2];

  logic              fill_vc;
  logic              drain_vc;
  logic [NREQ-1:0]   eligible;
  logic [2*NREQ-1:0] elig_dbl;
  logic [NREQ-1:0]   elig_rot;
  logic [PW:0]       cand;
  logic              gnt_any;
  logic [PW-1:0]     gnt_idx;
  logic [PW-1:0]     gnt_next_ptr;
  logic [DW-1:0]     gnt_pkt;
  logic              drain_fire;
  logic              drain_stall;

  assign fill_vc     = polarity;
  assign drain_vc    = ~polarity;
  assign drain_fire  = full[drain_vc] & ro;
  assign drain_stall = full[drain_vc] & ~ro;

  // A requester competes only if its packet's VC bit matches the filling VC and that buffer is free.
  for (genvar g = 0; g < NREQ; g++) begin : g_elig
    assign eligible[g] = req[g] & (din[g*DW + DW-1] == fill_vc) & ~full[fill_vc];
  end

  // Round-robin search: rotate so the pointer's channel sits at bit 0, take the lowest set bit.
  always_comb begin
    elig_dbl = {eligible, eligible} >> ptr[fill_vc];
    elig_rot = elig_dbl[NREQ-1:0];
    gnt_any  = 1'b0;
    cand     = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (elig_rot[k]) begin
        gnt_any = 1'b1;
        cand    = (PW+1)'(k) + {1'b0, ptr[fill_vc]};
      end
    end
    if (cand >= (PW+1)'(NREQ)) cand = cand - (PW+1)'(NREQ);
    gnt_idx      = cand[PW-1:0];
    gnt_next_ptr = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
  end

  // One-hot grant (held off during reset) and the granted channel's packet.
  always_comb begin
    gnt     = '0;
    gnt_pkt = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == PW'(i)) begin
        gnt[i]  = gnt_any & reset;
        gnt_pkt = din[i*DW +: DW];
      end
    end
  end

  // Phase toggle, buffer fill on the filling VC and buffer release on the draining VC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      polarity  <= 1'b0;
      full      <= '0;
      vc_buf[0] <= '0;
      vc_buf[1] <= '0;
      ptr[0]    <= '0;
      ptr[1]    <= '0;
    end else begin
      polarity <= ~polarity;
      if (gnt_any) begin
        vc_buf[fill_vc] <= gnt_pkt;
        full[fill_vc]   <= 1'b1;
        ptr[fill_vc]    <= gnt_next_ptr;
      end
      if (drain_fire) full[drain_vc] <= 1'b0;
    end
  end

  // Link side: registered send strobe and packet, plus saturating count of blocked drains.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      so        <= 1'b0;
      dout      <= '0;
      stall_cnt <= '0;
    end else begin
      so <= drain_fire;
      if (drain_fire) dout <= vc_buf[drain_vc];
      if (drain_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
